// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg
//   Shared definitions for the pulse meter: FSM state encoding and the
//   default counter widths used by the interface and the top module.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/pulse_meter_if.sv
// pulse_meter_if
//   Bundles the pulse meter's stimulus inputs and measurement results.
//   Signals:
//     enable       measurement enable (into the meter)
//     signal       asynchronous pulse input (into the meter)
//     high_len     high width of the last complete period
//     low_len      low width of the last complete period
//     pulse_count  number of complete periods measured (wrapping)
//     valid        one-cycle strobe marking fresh high_len/low_len
//     overflow     a counter saturated during the reported period
//   Modports:
//     master  the meter itself (drives the results)
//     slave   the pulse source / monitor side
interface pulse_meter_if
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             enable;
  logic             signal;
  logic [WIDTH-1:0] high_len;
  logic [WIDTH-1:0] low_len;
  logic [CNT_W-1:0] pulse_count;
  logic             valid;
  logic             overflow;

  modport master (
    input  enable, signal,
    output high_len, low_len, pulse_count, valid, overflow
  );

  modport slave (
    output enable, signal,
    input  high_len, low_len, pulse_count, valid, overflow
  );

endinterface

// File: rtl/pulse_meter_sync2.sv
// sync2
//   Two-flop synchronizer bringing an asynchronous level into the clock
//   domain. Both flops clear on reset.
//   Ports:
//     clock    system clock
//     reset_n  asynchronous active-low reset
//     d        asynchronous input
//     q        synchronized output (two edges of latency)
module sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter
//   Measures each complete period of an asynchronous pulse train. After
//   every rise that closes a period it reports the preceding high and low
//   widths in clock cycles, a wrapping period count and a saturation flag.
//   Ports:
//     clock    system clock, all state changes on the rising edge
//     reset_n  asynchronous active-low reset
//     bus      pulse_meter_if master: enable/signal in, results out
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic           clock,
  input  logic           reset_n,
  pulse_meter_if.master  bus
);

  localparam logic [WIDTH-1:0] LEN_MAX = '1;
  localparam logic [WIDTH-1:0] LEN_ONE = WIDTH'(1);

  state_t           state, state_next;
  logic             s_sync, s_prev;
  logic             rise, fall;
  logic [WIDTH-1:0] hcnt, hcnt_next;
  logic [WIDTH-1:0] lcnt, lcnt_next;
  logic [WIDTH-1:0] h_cap, h_cap_next;
  logic             sat_flag, sat_flag_next;
  logic [WIDTH-1:0] high_q, high_next;
  logic [WIDTH-1:0] low_q, low_next;
  logic [CNT_W-1:0] count_q, count_next;
  logic             ovf_q, ovf_next;
  logic             valid_q, valid_next;

  sync2 u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.signal),
    .q       (s_sync)
  );

  // Edge detection on the synchronized level; rise and fall share the same
  // latency so measured widths equal the true widths in cycles.
  assign rise = s_sync & ~s_prev;
  assign fall = ~s_sync & s_prev;

  // All state, counters and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      s_prev   <= 1'b0;
      hcnt     <= '0;
      lcnt     <= '0;
      h_cap    <= '0;
      sat_flag <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_next;
      s_prev   <= s_sync;
      hcnt     <= hcnt_next;
      lcnt     <= lcnt_next;
      h_cap    <= h_cap_next;
      sat_flag <= sat_flag_next;
      high_q   <= high_next;
      low_q    <= low_next;
      count_q  <= count_next;
      ovf_q    <= ovf_next;
      valid_q  <= valid_next;
    end
  end

  // Next-state logic. Counters stop at their maximum rather than wrapping,
  // and an attempted increment past the maximum marks the period as
  // saturated. A rise in LOW both closes the current period and opens the
  // next one with hcnt=1.
  always_comb begin
    state_next    = state;
    hcnt_next     = hcnt;
    lcnt_next     = lcnt;
    h_cap_next    = h_cap;
    sat_flag_next = sat_flag;
    high_next     = high_q;
    low_next      = low_q;
    count_next    = count_q;
    ovf_next      = ovf_q;
    valid_next    = 1'b0;

    if (!bus.enable) begin
      state_next    = IDLE;
      hcnt_next     = '0;
      lcnt_next     = '0;
      sat_flag_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_next    = HIGH;
            hcnt_next     = LEN_ONE;
            sat_flag_next = 1'b0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_next = LOW;
            h_cap_next = hcnt;
            lcnt_next  = LEN_ONE;
          end else if (hcnt == LEN_MAX) begin
            sat_flag_next = 1'b1;
          end else begin
            hcnt_next = hcnt + LEN_ONE;
          end
        end
        LOW: begin
          if (rise) begin
            state_next    = HIGH;
            high_next     = h_cap;
            low_next      = lcnt;
            ovf_next      = sat_flag;
            count_next    = count_q + CNT_W'(1);
            valid_next    = 1'b1;
            hcnt_next     = LEN_ONE;
            sat_flag_next = 1'b0;
          end else if (lcnt == LEN_MAX) begin
            sat_flag_next = 1'b1;
          end else begin
            lcnt_next = lcnt + LEN_ONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.high_len    = high_q;
  assign bus.low_len     = low_q;
  assign bus.pulse_count = count_q;
  assign bus.valid       = valid_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Receive-side counterpart to the lab pulse generators: samples an asynchronous pulse train on `signal`, synchronizes it to `clock`, and measures each complete period. On each rising edge after a full period it reports the preceding high width and low width (in clock cycles), a running period count, and a saturation flag. It sits between any pulse source and the bench monitor, and serves as a self-checking observer for generated waveforms.

## Interface
- `WIDTH`, 8, width of the high/low length counters and outputs
- `CNT_W`, 8, width of the period counter
- `clock`  in  1  system clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  measurement enable; low forces IDLE
- `signal`  in  1  asynchronous pulse input
- `high_len`  out  WIDTH  high width of the last complete period, in cycles
- `low_len`  out  WIDTH  low width of the last complete period, in cycles
- `pulse_count`  out  CNT_W  number of complete periods measured; wraps at 2^CNT_W
- `valid`  out  1  one-cycle strobe; new `high_len`/`low_len` are valid
- `overflow`  out  1  a counter saturated during the reported period; updates with `valid`

## Operation
- `signal` passes through a two-flop synchronizer giving `s_sync`. `s_prev` is `s_sync` delayed one cycle. `rise = s_sync & ~s_prev`. `fall = ~s_sync & s_prev`.
- The FSM has three states: IDLE, HIGH, LOW.
  - IDLE: on `rise`, go to HIGH, set hcnt=1, clear the period saturation flag.
  - HIGH: hcnt += 1 each cycle. On `fall`, go to LOW, capture hcnt into h_cap, set lcnt=1.
  - LOW: lcnt += 1 each cycle. On `rise`, go to HIGH and in the same edge:
    - `high_len` <= h_cap, `low_len` <= lcnt, `overflow` <= period saturation flag
    - `pulse_count` += 1 (modulo 2^CNT_W), `valid` <= 1
    - hcnt=1, flag cleared
- Counters saturate at 2^WIDTH-1 and never wrap. Any saturation sets the period flag.
- `valid` is high for exactly one cycle. Results hold until the next `valid`.
- `enable` low: the next edge forces IDLE and clears hcnt, lcnt and the flag. Outputs hold and no `valid` is produced. After re-enable, the first `valid` requires a full period (rise, fall, rise).
- Reset (asynchronous, any time):
  - all outputs 0, state IDLE
  - synchronizer flops 0, counters 0
  - a partial period in progress is discarded
- Edges on `signal` closer together than one clock cycle are not guaranteed to be seen. Each level lasting ≥1 cycle is measured exactly.

## Timing
- A level change on `signal` captured by synchronizer flop 1 at edge k is in `s_sync` after edge k+1. `rise`/`fall` are asserted in the following cycle, and the FSM acts at edge k+2.
- `valid` is high for the cycle after edge k+2 of the rising edge that closes a period. Total latency is 3 edges from capture.
- Rise and fall share the same latency, so a synchronous high of N cycles yields `high_len`=N, and the same holds for low.
- Minimum measurable period is 2 cycles (high=1, low=1).
- A `rise` in IDLE never produces `valid`.

## Structure
- `pulse_meter_pkg` defines the state typedef with IDLE=2'b00, HIGH=2'b01, LOW=2'b10, plus the default `WIDTH`/`CNT_W` constants.
- Sub-module `sync2` is the two-flop synchronizer. It has the same `clock`/`reset_n` and resets to 0.
- The FSM, counters and output registers live in `pulse_meter`.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles with `signal` toggling. Require all outputs 0 and no `valid`. Asserting reset mid-HIGH forces outputs 0 immediately, without waiting for a clock edge.
- Square wave high=3, low=5 cycles, 4 periods. Require 3 `valid` strobes 8 cycles apart, each with `high_len`=3, `low_len`=5, `overflow`=0, and `pulse_count`=1,2,3.
- Minimum period high=1, low=1. Require `valid` every 2 cycles with `high_len`=1 and `low_len`=1.
- `WIDTH`=4, high=20, low=2. Require `high_len`=15, `low_len`=2, `overflow`=1. The next normal period reports `overflow`=0.
- Drop `enable` for 2 cycles mid-LOW. Require no `valid` for that period. After re-enable, the first `valid` comes only after a full rise-fall-rise.
- `CNT_W`=2, 5 periods. Require `pulse_count` sequence 1,2,3,0.
